// File: rtl/word_serializer_pkg.sv
// Shared types and constants for the MSB-first word serializer.
package word_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Width of a counter indexing bits WIDTH-1..0; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: accepts a word on a valid/ready handshake and
// emits it MSB-first, flagging the first and last bit of each word.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_word,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             Bit,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             first_bit,
    output logic             last_bit,
    output logic             busy,
    output state_e           dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load;
    logic             shifting;

    // Handshakes: a word moves when in_valid && in_ready at a rising edge, and a
    // bit moves when bit_valid && bit_ready; a sender holds its data until taken.
    assign shifting = (state_q == SHIFT);

    // in_ready reaches back to bit_ready so the next word loads on the last bit.
    assign in_ready = !reset &&
                      ((state_q == IDLE) ||
                       (shifting && (cnt_q == '0) && bit_ready));

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_ready) begin
                    if (cnt_q != '0) begin
                        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                        cnt_d  = cnt_q - CNT_W'(1);
                    end else if (in_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        sreg_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            sreg_d  = in_word;
            cnt_d   = CNT_LAST;
            state_d = SHIFT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Serial outputs decode registered state only.
    assign Bit       = shifting && sreg_q[WIDTH-1];
    assign bit_valid = shifting;
    assign busy      = shifting;
    assign first_bit = shifting && (cnt_q == CNT_LAST);
    assign last_bit  = shifting && (cnt_q == '0);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: directed scenarios plus random traffic, checked
// against a bit-queue reference model; a second instance covers WIDTH=2.
module tb_word_serializer;
    import word_serializer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_word;
    logic       in_valid, in_ready, s_bit, bit_valid, bit_ready;
    logic       first_bit, last_bit, busy;
    state_e     dbg_state;

    logic [1:0] in_word2;
    logic       in_valid2, in_ready2, s_bit2, bit_valid2, bit_ready2;
    logic       first_bit2, last_bit2, busy2;
    state_e     dbg_state2;

    int total = 0;
    int bad   = 0;

    logic       exp_q[$];
    logic [7:0] word_q[$];
    logic [7:0] col;

    always #5 clk = ~clk;

    word_serializer #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid),
        .in_ready(in_ready), .Bit(s_bit), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .first_bit(first_bit), .last_bit(last_bit),
        .busy(busy), .dbg_state(dbg_state)
    );

    word_serializer #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .in_word(in_word2), .in_valid(in_valid2),
        .in_ready(in_ready2), .Bit(s_bit2), .bit_valid(bit_valid2),
        .bit_ready(bit_ready2), .first_bit(first_bit2), .last_bit(last_bit2),
        .busy(busy2), .dbg_state(dbg_state2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on the WIDTH=8 instance: drive, then check against the model
    // and advance the model through the coming edge.
    task automatic cyc(input logic iv, input logic [7:0] w, input logic br,
                       output logic acc);
        int   n;
        logic ev, er;
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_word   = w;
        bit_ready = br;
        @(negedge clk);
        n  = exp_q.size();
        ev = (n != 0);
        er = !ev || ((n == 1) && br);
        chk("bit_valid", bit_valid, ev);
        chk("busy", busy, ev);
        chk("first_bit", first_bit, ev && (n == 8));
        chk("last_bit", last_bit, ev && (n == 1));
        chk("in_ready", in_ready, er);
        if (ev) chk("bit", s_bit, exp_q[0]);
        acc = iv && er;
        if (ev && br) begin
            col = {col[6:0], s_bit};
            if (n == 1 && word_q.size() != 0) chk("word", col, word_q.pop_front());
            void'(exp_q.pop_front());
        end
        if (acc) begin
            word_q.push_back(w);
            for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
        end
    endtask

    task automatic run(input logic iv, input logic [7:0] w, input logic br, input int n);
        logic acc;
        for (int i = 0; i < n; i++) cyc(iv, w, br, acc);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_bit_valid"}, bit_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_bit"}, s_bit, 1'b0);
        chk({tag, "_first"}, first_bit, 1'b0);
        chk({tag, "_last"}, last_bit, 1'b0);
    endtask

    initial begin
        logic       acc, pend, br;
        logic [7:0] rw;
        logic [1:0] w2;

        reset = 1'b1;
        in_word = '0; in_valid = 1'b0; bit_ready = 1'b1;
        in_word2 = '0; in_valid2 = 1'b0; bit_ready2 = 1'b1;
        col = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_bit_valid", bit_valid, 1'b0);

        // Single word 0x06.
        cyc(1'b1, 8'h06, 1'b1, acc);
        chk("single_acc", acc, 1'b1);
        run(1'b0, 8'h00, 1'b1, 9);

        // Back-to-back 0x07 then 0x09 with in_valid held.
        cyc(1'b1, 8'h07, 1'b1, acc);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 8'h09, 1'b1, acc);
            chk("b2b_accept_slot", acc, (i == 7));
        end
        run(1'b0, 8'h00, 1'b1, 9);

        // Backpressure: stall three cycles after the third bit of 0xA5.
        cyc(1'b1, 8'hA5, 1'b1, acc);
        run(1'b0, 8'h00, 1'b1, 3);
        run(1'b0, 8'h00, 1'b0, 3);
        run(1'b0, 8'h00, 1'b1, 6);

        // Busy ignore: 0xFF offered mid-word, taken only at the last bit.
        cyc(1'b1, 8'h3C, 1'b1, acc);
        run(1'b0, 8'h00, 1'b1, 2);
        run(1'b1, 8'hFF, 1'b1, 6);
        run(1'b0, 8'h00, 1'b1, 9);

        // Reset in the middle of 0xF0, then a clean 0x03.
        cyc(1'b1, 8'hF0, 1'b1, acc);
        run(1'b0, 8'h00, 1'b1, 3);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        exp_q.delete();
        word_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_release_in_ready", in_ready, 1'b1);
        chk("midrst_release_bit_valid", bit_valid, 1'b0);
        cyc(1'b1, 8'h03, 1'b1, acc);
        run(1'b0, 8'h00, 1'b1, 9);

        // Random traffic with random backpressure; upstream holds until taken.
        pend = 1'b0;
        rw   = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pend && $urandom_range(0, 2) != 0) begin
                pend = 1'b1;
                rw   = 8'($urandom);
            end
            br = ($urandom_range(0, 3) != 0);
            cyc(pend, rw, br, acc);
            if (acc) pend = 1'b0;
        end
        run(1'b0, 8'h00, 1'b1, 12);
        chk("drain_empty", exp_q.size(), 0);

        // WIDTH=2 instance.
        for (int k = 0; k < 6; k++) begin
            w2 = (k == 0) ? 2'b11 : 2'($urandom);
            @(posedge clk);
            #1 in_valid2 = 1'b1; in_word2 = w2; bit_ready2 = 1'b1;
            @(negedge clk);
            chk("w2_idle_in_ready", in_ready2, 1'b1);
            chk("w2_idle_bit_valid", bit_valid2, 1'b0);
            @(posedge clk);
            #1 in_valid2 = 1'b0;
            @(negedge clk);
            chk("w2_b1_valid", bit_valid2, 1'b1);
            chk("w2_b1_bit", s_bit2, w2[1]);
            chk("w2_b1_first", first_bit2, 1'b1);
            chk("w2_b1_last", last_bit2, 1'b0);
            chk("w2_b1_in_ready", in_ready2, 1'b0);
            @(posedge clk);
            @(negedge clk);
            chk("w2_b2_valid", bit_valid2, 1'b1);
            chk("w2_b2_bit", s_bit2, w2[0]);
            chk("w2_b2_first", first_bit2, 1'b0);
            chk("w2_b2_last", last_bit2, 1'b1);
            chk("w2_b2_in_ready", in_ready2, 1'b1);
            @(posedge clk);
            @(negedge clk);
            chk("w2_done_valid", bit_valid2, 1'b0);
            chk("w2_done_busy", busy2, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
